// File: rtl/sha3_pkg.sv
// Shared constants, block type and state encoding for the SHA3-512 pad buffer.
// Imported by the lane padder and the buffer top level.
package sha3_pkg;

    localparam int RATE_BITS = 576;
    localparam int WORD_W    = 64;
    localparam int LANES     = RATE_BITS / WORD_W;

    localparam logic [7:0] SHA3_DS  = 8'h06;
    localparam logic [7:0] SHA3_END = 8'h80;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PADX = 2'd2
    } state_e;

    typedef logic [LANES-1:0][WORD_W-1:0] block_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Combinational lane padder: keeps the valid bytes of a word, zeroes the rest
// and drops the SHA3 domain byte right after the last message byte.
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        bytes,
    input  logic              last,
    output logic [WORD_W-1:0] lane,
    output logic              full
);

    logic [3:0] k;

    // Clamp the byte count and build the masked, padded lane
    always_comb begin
        k    = (bytes > 4'd8) ? 4'd8 : bytes;
        full = !last || (k == 4'd8);
        lane = '0;
        for (int i = 0; i < 8; i++) begin
            if (!last || i < int'(k)) begin
                lane[8*i +: 8] = word[8*i +: 8];
            end else if (i == int'(k)) begin
                lane[8*i +: 8] = SHA3_DS;
            end
        end
    end

endmodule

// File: rtl/sha3_pad_buffer.sv
// Packs 64-bit message words into padded 576-bit SHA3-512 rate blocks and
// hands each block to the absorb stage over a valid/ready handshake.
module sha3_pad_buffer
    import sha3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    input  logic [3:0]           in_bytes,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [RATE_BITS-1:0] blk_data,
    output logic                 blk_last
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    block_t      buf_q, buf_d;
    logic        last_q, last_d;
    logic        padx_q, padx_d;
    logic [WORD_W-1:0] lane;
    logic        lane_full;

    sha3_pad_lane u_lane (
        .word  (in_data),
        .bytes (in_bytes),
        .last  (in_last),
        .lane  (lane),
        .full  (lane_full)
    );

    // Next-state, buffer update and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        last_d    = last_q;
        padx_d    = padx_q;
        in_ready  = rst && (state_q == FILL);
        blk_valid = (state_q == EMIT);

        unique case (state_q)
            FILL: begin
                if (in_valid && in_ready) begin
                    buf_d[cnt_q] = lane;
                    if (!in_last) begin
                        if (cnt_q == 4'(LANES - 1)) begin
                            last_d  = 1'b0;
                            state_d = EMIT;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (!lane_full) begin
                        buf_d[LANES-1][WORD_W-1] = 1'b1;
                        last_d  = 1'b1;
                        state_d = EMIT;
                    end else if (cnt_q != 4'(LANES - 1)) begin
                        buf_d[cnt_q + 4'd1] = {56'd0, SHA3_DS};
                        buf_d[LANES-1][WORD_W-1] = 1'b1;
                        last_d  = 1'b1;
                        state_d = EMIT;
                    end else begin
                        last_d  = 1'b0;
                        padx_d  = 1'b1;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    buf_d   = '0;
                    cnt_d   = 4'd0;
                    last_d  = 1'b0;
                    padx_d  = 1'b0;
                    state_d = padx_q ? PADX : FILL;
                end
            end
            PADX: begin
                buf_d       = '0;
                buf_d[0]    = {56'd0, SHA3_DS};
                buf_d[LANES-1][WORD_W-1 -: 8] = SHA3_END;
                last_d      = 1'b1;
                state_d     = EMIT;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, counter and block buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            padx_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            padx_q  <= padx_d;
        end
    end

    assign blk_data = buf_q;
    assign blk_last = last_q;

endmodule
